// File: rtl/fft_256.sv
// Streaming 256-point complex FFT: bit-reversed frame load, in-place radix-2 DIT
// with one butterfly per cycle, then natural-order bin readout.
module fft_256 #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 16,
  parameter int STAGES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  output logic                     out_valid,
  output logic signed [15:0]       dout_r,
  output logic signed [15:0]       dout_i
);
  localparam int N     = 1 << STAGES;
  localparam int INT_W = 18;
  localparam int PRD_W = INT_W + COEF_W + 2;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  // sin(pi*k/128) in Q30 by Taylor series, k in 0..64; elaboration-time only
  function automatic longint sin_q30(input int k);
    longint x, x2, term, acc;
    x    = (64'sd3373259426 * longint'(k)) / 64'sd128;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int i = 1; i < 8; i++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic int q14(input longint v);
    return int'((v + 64'sd32768) >>> 16);
  endfunction

  function automatic int tw_cos_q14(input int m);
    if (m <= 64) return q14(sin_q30(64 - m));
    return -q14(sin_q30(m - 64));
  endfunction

  function automatic int tw_sin_q14(input int m);
    if (m <= 64) return q14(sin_q30(m));
    return q14(sin_q30(128 - m));
  endfunction

  function automatic logic [7:0] bitrev(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction

  function automatic logic signed [INT_W-1:0] rnd_q14(input logic signed [PRD_W-1:0] p);
    return INT_W'((p + PRD_W'(8192)) >>> 14);
  endfunction

  function automatic logic signed [INT_W-1:0] half_up(input logic signed [INT_W:0] s);
    return INT_W'((s + 19'sd1) >>> 1);
  endfunction

  function automatic logic signed [15:0] sat_out(input logic signed [INT_W-1:0] v);
    if (v > 18'sd32767) return 16'sd32767;
    if (v < -18'sd32768) return -16'sd32768;
    return v[15:0];
  endfunction

  // W = cos - j*sin for m = 0..127, Q1.14
  logic [N/2*COEF_W-1:0] tw_re_flat, tw_im_flat;
  for (genvar m = 0; m < N/2; m++) begin : g_tw
    localparam int TW_C = tw_cos_q14(m);
    localparam int TW_S = tw_sin_q14(m);
    assign tw_re_flat[m*COEF_W +: COEF_W] = COEF_W'(TW_C);
    assign tw_im_flat[m*COEF_W +: COEF_W] = COEF_W'(-TW_S);
  end

  logic signed [INT_W-1:0] mem_r [N];
  logic signed [INT_W-1:0] mem_i [N];

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] stage;
  logic [7:0] bcnt;
  logic       vld_p0;
  logic       take;

  logic [7:0] mask, pos, addr_a, addr_b;
  logic [6:0] tw_m;

  logic [7:0]                ia_p0, ib_p0;
  logic signed [INT_W-1:0]   a_r_p0, a_i_p0, b_r_p0, b_i_p0;
  logic signed [COEF_W-1:0]  w_r_p0, w_i_p0;
  logic signed [PRD_W-1:0]   pr, pq;
  logic signed [INT_W-1:0]   t_r, t_i;

  // the output register lags the FSM by one cycle, so hold off loading until it drains
  assign take = (state == LOAD) && in_valid && !out_valid;

  always_comb begin
    mask   = (8'd1 << stage) - 8'd1;
    pos    = {1'b0, bcnt[6:0]} & mask;
    addr_a = (({1'b0, bcnt[6:0]} & ~mask) << 1) | pos;
    addr_b = addr_a | (8'd1 << stage);
    tw_m   = 7'(pos << (3'd7 - stage));
  end

  // p0: operand fetch
  always_ff @(posedge clk) begin
    ia_p0  <= addr_a;
    ib_p0  <= addr_b;
    a_r_p0 <= mem_r[addr_a];
    a_i_p0 <= mem_i[addr_a];
    b_r_p0 <= mem_r[addr_b];
    b_i_p0 <= mem_i[addr_b];
    w_r_p0 <= tw_re_flat[int'(tw_m) * COEF_W +: COEF_W];
    w_i_p0 <= tw_im_flat[int'(tw_m) * COEF_W +: COEF_W];
  end

  // p1: twiddle multiply, butterfly, halving and write-back
  always_comb begin
    pr  = PRD_W'(b_r_p0) * PRD_W'(w_r_p0) - PRD_W'(b_i_p0) * PRD_W'(w_i_p0);
    pq  = PRD_W'(b_r_p0) * PRD_W'(w_i_p0) + PRD_W'(b_i_p0) * PRD_W'(w_r_p0);
    t_r = rnd_q14(pr);
    t_i = rnd_q14(pq);
  end

  // samples enter pre-scaled by 16 so the final gain keeps the halvings' fraction bits
  always_ff @(posedge clk) begin
    if (take) begin
      mem_r[bitrev(cnt)] <= INT_W'(din_r) <<< 4;
      mem_i[bitrev(cnt)] <= INT_W'(din_i) <<< 4;
    end
    if (vld_p0) begin
      mem_r[ia_p0] <= half_up((INT_W+1)'(a_r_p0) + (INT_W+1)'(t_r));
      mem_i[ia_p0] <= half_up((INT_W+1)'(a_i_p0) + (INT_W+1)'(t_i));
      mem_r[ib_p0] <= half_up((INT_W+1)'(a_r_p0) - (INT_W+1)'(t_r));
      mem_i[ib_p0] <= half_up((INT_W+1)'(a_i_p0) - (INT_W+1)'(t_i));
    end
  end

  // bcnt = 128 is a bubble so a stage's last write lands before the next stage reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      stage     <= '0;
      bcnt      <= '0;
      vld_p0    <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      vld_p0    <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
      unique case (state)
        LOAD: begin
          if (take) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'd255) begin
              state <= CALC;
              stage <= '0;
              bcnt  <= '0;
            end
          end
        end
        CALC: begin
          if (!bcnt[7]) begin
            vld_p0 <= 1'b1;
            bcnt   <= bcnt + 8'd1;
          end else begin
            bcnt  <= '0;
            stage <= stage + 3'd1;
            if (stage == 3'd7) begin
              state <= OUT;
              cnt   <= '0;
            end
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          dout_r    <= sat_out(mem_r[cnt]);
          dout_i    <= sat_out(mem_i[cnt]);
          cnt       <= cnt + 8'd1;
          if (cnt == 8'd255) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_256.sv
// Directed bench for fft_256: impulse, DC, tone, gapped timing, saturation and
// reset-abort frames, each checked against hand-derived bin values.
module tb_fft_256;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [11:0] din_r = '0;
  logic signed [11:0] din_i = '0;
  logic               out_valid;
  logic signed [15:0] dout_r;
  logic signed [15:0] dout_i;

  fft_256 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .din_r    (din_r),
    .din_i    (din_i),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_i   (dout_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xr[256], xi[256];
  int yr[256], yi[256];
  int lat = 0;
  int lat_ref = -1;

  task automatic check(input string tag, input integer got, input integer lo, input integer hi);
    checks++;
    assert ((got >= lo && got <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic drive_frame(input bit gaps);
    for (int n = 0; n < 256; n++) begin
      if (gaps && (n % 4 == 1)) begin
        @(negedge clk);
        in_valid = 1'b0;
        din_r = 12'sd5;
        din_i = -12'sd5;
      end
      @(negedge clk);
      in_valid = 1'b1;
      din_r = 12'(xr[n]);
      din_i = 12'(xi[n]);
    end
    @(posedge clk);
  endtask

  task automatic collect(input string tag, input bit junk);
    int cyc;
    int nv;
    bit quiet;
    cyc = 0;
    nv = 0;
    quiet = 1'b1;
    #1;
    in_valid = junk;
    din_r = 12'sd700;
    din_i = -12'sd300;
    while (cyc < 1300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 150) in_valid = 1'b0;
      if (out_valid === 1'b1) break;
      if (dout_r !== '0 || dout_i !== '0) quiet = 1'b0;
    end
    in_valid = 1'b0;
    lat = cyc;
    while (out_valid === 1'b1 && nv < 300) begin
      if (nv < 256) begin
        yr[nv] = 32'(dout_r);
        yi[nv] = 32'(dout_i);
      end
      nv++;
      @(posedge clk);
      #1;
    end
    check({tag, "_quiet_before"}, quiet, 1, 1);
    check({tag, "_valid_len"}, nv, 256, 256);
    check({tag, "_dout_r_after"}, 32'(dout_r), 0, 0);
    check({tag, "_dout_i_after"}, 32'(dout_i), 0, 0);
    if (lat_ref < 0) begin
      lat_ref = lat;
      check({tag, "_latency"}, lat, 1, 1200);
    end else begin
      check({tag, "_latency"}, lat, lat_ref, lat_ref);
    end
  endtask

  task automatic check_bins(input string tag, input int k1, input int k2,
                            input int plo, input int phi, input int olo, input int ohi);
    for (int k = 0; k < 256; k++) begin
      if (k == k1 || k == k2) check($sformatf("%s[%0d]_re", tag, k), yr[k], plo, phi);
      else check($sformatf("%s[%0d]_re", tag, k), yr[k], olo, ohi);
      check($sformatf("%s[%0d]_im", tag, k), yi[k], -3, 3);
    end
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 256; n++) begin
      xr[n] = (n == 0) ? 1600 : 0;
      xi[n] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_dout_r", 32'(dout_r), 0, 0);
    check("rst_dout_i", 32'(dout_i), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_impulse();
    drive_frame(1'b0);
    collect("impulse", 1'b0);
    check_bins("impulse", -1, -1, 0, 0, 97, 103);

    for (int n = 0; n < 256; n++) begin
      xr[n] = 160;
      xi[n] = 0;
    end
    drive_frame(1'b0);
    collect("dc", 1'b0);
    check_bins("dc", 0, 0, 2557, 2563, -3, 3);

    for (int n = 0; n < 256; n++) begin
      xr[n] = rnd(1000.0 * $cos(2.0 * 3.14159265358979 * 8.0 * n / 256.0));
      xi[n] = 0;
    end
    drive_frame(1'b0);
    collect("tone", 1'b0);
    check_bins("tone", 8, 248, 7997, 8003, -3, 3);

    set_impulse();
    drive_frame(1'b1);
    collect("gapped", 1'b1);
    check_bins("gapped", -1, -1, 0, 0, 97, 103);

    for (int n = 0; n < 256; n++) begin
      xr[n] = rnd(2047.0 * $cos(2.0 * 3.14159265358979 * n / 256.0));
      xi[n] = rnd(2047.0 * $sin(2.0 * 3.14159265358979 * n / 256.0));
    end
    drive_frame(1'b0);
    collect("sat", 1'b0);
    check_bins("sat", 1, 1, 32749, 32767, -3, 3);

    for (int n = 0; n < 256; n++) begin
      xr[n] = 1000;
      xi[n] = -1000;
    end
    drive_frame(1'b0);
    #1;
    in_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rst_out_valid", out_valid, 0, 0);
    check("abort_rst_dout_r", 32'(dout_r), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    repeat (1300) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ov_cnt++;
    end
    check("abort_no_output", ov_cnt, 0, 0);

    set_impulse();
    drive_frame(1'b0);
    collect("fresh", 1'b0);
    check_bins("fresh", -1, -1, 0, 0, 97, 103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
